mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory port between instruction fetch (I) and data access (D) in the 16-bit CPU.
//  Sequences the readM/writeM handshake with memory.
//  Drives the address-select for the PC/ALU address mux.
//  Returns read data and a one-cycle done pulse to the winning requester.
//  Sits between the CPU datapath/control and the external memory model.
// PARAMETERS
//  WORD_W  16  data word width
//  ADDR_W  16  address width
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  i_req        in   1       fetch request, held high until i_done
//  i_addr       in   ADDR_W  fetch address (PC)
//  d_req        in   1       data request, held high until d_done
//  d_we         in   1       1=write, 0=read; sampled at grant
//  d_addr       in   ADDR_W  data address (ALU result)
//  d_wdata      in   WORD_W  store data; sampled at grant
//  i_done       out  1       1-cycle pulse: fetch complete, rdata valid this cycle
//  d_done       out  1       1-cycle pulse: data access complete
//  rdata        out  WORD_W  registered read data (fetch or load)
//  readM        out  1       memory read strobe
//  writeM       out  1       memory write strobe
//  address      out  ADDR_W  memory address
//  wdata        out  WORD_W  memory write data
//  addr_sel     out  1       0=PC path, 1=data path; drives address mux
//  inputReady   in   1       memory: read data valid on mem_rdata
//  mem_rdata    in   WORD_W  memory read data
//  ackOutput    in   1       memory: write accepted
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE, last=D
//   - readM=writeM=i_done=d_done=addr_sel=0
//   - address=wdata=rdata=0
//   - any in-flight transaction is abandoned; no done pulse
//  States: IDLE, I_RD, D_RD, D_WR. All outputs are registered.
//  IDLE, arbitration:
//   - only one request pending -> grant it
//   - both pending -> grant the one not in `last` (round-robin)
//  Grant sampled at edge N:
//   - address/addr_sel/wdata are latched
//   - at N+1, readM (I, or D with d_we=0) or writeM (D with d_we=1) is high
//   - `last` is updated to the granted requester
//  I_RD / D_RD:
//   - hold readM and address stable until inputReady=1 sampled at edge M
//   - at M+1: readM=0, rdata=mem_rdata, matching done=1 for exactly one cycle, state=IDLE
//  D_WR:
//   - hold writeM/address/wdata until ackOutput=1 sampled at M
//   - at M+1: writeM=0, d_done=1, state=IDLE; rdata unchanged
//  Same-cycle ready: read ready/ack in the cycle after issue -> 2-cycle access. Earliest next grant is at edge M+1 (IDLE), strobe at M+2.
//  Ignored inputs:
//   - inputReady in IDLE or D_WR
//   - ackOutput in IDLE or read states
//   - both asserted: only the one matching the current state counts
//  A request dropped mid-transaction does not abort it; the done pulse still fires.
//  addr_sel, address and wdata hold their last values in IDLE.
//  readM and writeM are never high together.
//  Requester must deassert req in the done cycle or it is re-arbitrated as a new request.
// STRUCTURE
//  Shared package: WORD_W/ADDR_W defaults; state encodings ST_IDLE, ST_I_RD, ST_D_RD, ST_D_WR (2 bits); REQ_I/REQ_D.
//  Sub-module: the team 2:1 mux (mux_2_to_1) selects i_addr/d_addr by the next-grant select, feeding the address register.
//  Remainder is one FSM always-block plus output registers.
// TESTING
//  1. i_req=1, i_addr=0x0010; inputReady 3 cycles after readM, mem_rdata=0xA5A5 -> i_done pulse 1 cycle, rdata=0xA5A5, addr_sel=0.
//  2. d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234; ack after 2 cycles -> writeM held with addr 0x0040/data 0x1234, d_done 1 cycle, readM never high.
//  3. i_req and d_req both high from reset, last=D -> I granted first, then D; repeat, check strict alternation over 4 grants.
//  4. Both inputReady and ackOutput high during D_RD, mem_rdata=0x00FF -> treated as read complete, rdata=0x00FF, d_done only.
//  5. reset_n low for 1 cycle during I_RD -> readM=0 immediately (async), no i_done, IDLE after release; re-grant when i_req held.
//  6. inputReady pulse in IDLE with no request -> no state change, no done, rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned DEF_WORD_W = 16;
    localparam int unsigned DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_I_RD = 2'd1,
        ST_D_RD = 2'd2,
        ST_D_WR = 2'd3
    } state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [WORD_W-1:0] d_wdata;
    logic              i_done;
    logic              d_done;
    logic [WORD_W-1:0] rdata;
    logic              readM;
    logic              writeM;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] wdata;
    logic              addr_sel;
    logic              inputReady;
    logic [WORD_W-1:0] mem_rdata;
    logic              ackOutput;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  inputReady, mem_rdata, ackOutput,
        output i_done, d_done, rdata, readM, writeM, address, wdata, addr_sel
    );

    // CPU datapath/control and memory model side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output inputReady, mem_rdata, ackOutput,
        input  i_done, d_done, rdata, readM, writeM, address, wdata, addr_sel
    );

endinterface

// File: rtl/mem_port_arbiter_mux_2_to_1.sv
// Team 2:1 mux: sel=0 passes a, sel=1 passes b.
module mux_2_to_1 #(
    parameter int unsigned W = 16
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y_c
);

    assign y_c = sel ? b : a;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (I) and data (D)
// requesters; sequences the readM/writeM handshake and returns data + done.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.slave   bus
);

    state_e            state, state_nxt;
    req_e              last, last_nxt;
    logic              read_q, read_nxt;
    logic              write_q, write_nxt;
    logic              i_done_q, i_done_nxt;
    logic              d_done_q, d_done_nxt;
    logic              addr_sel_q, addr_sel_nxt;
    logic [ADDR_W-1:0] address_q, address_nxt;
    logic [WORD_W-1:0] wdata_q, wdata_nxt;
    logic [WORD_W-1:0] rdata_q, rdata_nxt;

    logic              grant_i_c;
    logic              grant_d_c;
    logic [ADDR_W-1:0] grant_addr_c;

    // D wins when it is alone or when I was served last; otherwise I wins.
    assign grant_d_c = bus.d_req && (!bus.i_req || (last == REQ_I));
    assign grant_i_c = bus.i_req && !grant_d_c;

    mux_2_to_1 #(.W(ADDR_W)) u_addr_mux (
        .sel (grant_d_c),
        .a   (bus.i_addr),
        .b   (bus.d_addr),
        .y_c (grant_addr_c)
    );

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last       <= REQ_D;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            addr_sel_q <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            last       <= last_nxt;
            read_q     <= read_nxt;
            write_q    <= write_nxt;
            i_done_q   <= i_done_nxt;
            d_done_q   <= d_done_nxt;
            addr_sel_q <= addr_sel_nxt;
            address_q  <= address_nxt;
            wdata_q    <= wdata_nxt;
            rdata_q    <= rdata_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        read_nxt     = read_q;
        write_nxt    = write_q;
        i_done_nxt   = 1'b0;
        d_done_nxt   = 1'b0;
        addr_sel_nxt = addr_sel_q;
        address_nxt  = address_q;
        wdata_nxt    = wdata_q;
        rdata_nxt    = rdata_q;

        unique case (state)
            ST_IDLE: begin
                if (grant_i_c) begin
                    state_nxt    = ST_I_RD;
                    last_nxt     = REQ_I;
                    read_nxt     = 1'b1;
                    addr_sel_nxt = 1'b0;
                    address_nxt  = grant_addr_c;
                end else if (grant_d_c) begin
                    last_nxt     = REQ_D;
                    addr_sel_nxt = 1'b1;
                    address_nxt  = grant_addr_c;
                    wdata_nxt    = bus.d_wdata;
                    if (bus.d_we) begin
                        state_nxt = ST_D_WR;
                        write_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_D_RD;
                        read_nxt  = 1'b1;
                    end
                end
            end
            ST_I_RD: begin
                if (bus.inputReady) begin
                    state_nxt  = ST_IDLE;
                    read_nxt   = 1'b0;
                    rdata_nxt  = bus.mem_rdata;
                    i_done_nxt = 1'b1;
                end
            end
            ST_D_RD: begin
                if (bus.inputReady) begin
                    state_nxt  = ST_IDLE;
                    read_nxt   = 1'b0;
                    rdata_nxt  = bus.mem_rdata;
                    d_done_nxt = 1'b1;
                end
            end
            ST_D_WR: begin
                if (bus.ackOutput) begin
                    state_nxt  = ST_IDLE;
                    write_nxt  = 1'b0;
                    d_done_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.readM    = read_q;
    assign bus.writeM   = write_q;
    assign bus.i_done   = i_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.addr_sel = addr_sel_q;
    assign bus.address  = address_q;
    assign bus.wdata    = wdata_q;
    assign bus.rdata    = rdata_q;

endmodule
